hamming_decode_unit: RTL and testbench

HAMMING_DECODE_UNIT -- requirements
Module: hamming_decode_unit

---
 rtl/hamming_decode_unit.sv | 184 ++++++++++++++++++
 tb/tb_hamming_decode_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : hamming_decode_unit
// Description : Reads NUM_WORDS 16-bit extended-Hamming (SECDED) codewords
//               from byte memory, corrects single-bit errors, detects
//               double-bit errors, and writes the 11 data bits plus two flag
//               bits back as two bytes per word.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_decode_unit #(
    parameter int IN_BASE   = 64,
    parameter int OUT_BASE  = 94,
    parameter int NUM_WORDS = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    // Base addresses and last word index, all in the 8-bit address domain.
    localparam logic [7:0] c_in_base  = IN_BASE[7:0];
    localparam logic [7:0] c_out_base = OUT_BASE[7:0];
    localparam logic [7:0] c_last_k   = 8'(NUM_WORDS - 1);

    // Flag encodings written into the top two bits of each output high byte.
    localparam logic [1:0] c_flag_clean     = 2'b00;
    localparam logic [1:0] c_flag_corrected = 2'b01;
    localparam logic [1:0] c_flag_double    = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        CHECK = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_k;          // current word index
    logic [7:0]  r_lo;         // latched codeword low byte
    logic [7:0]  r_hi;         // latched codeword high byte
    logic [10:0] r_data;       // decoded d[11:1], r_data[0] = d[1]
    logic [1:0]  r_flags;      // F for the current word
    logic        r_ack;

    logic [15:0] w_cw;
    logic [3:0]  w_syn;
    logic        w_par;
    logic [15:0] w_fix;
    logic [1:0]  w_flags;
    logic [10:0] w_data;
    logic        w_is_last;
    logic [7:0]  w_k_x2;
    logic [7:0]  w_in_addr;
    logic [7:0]  w_out_addr;
    logic        w_unused_parity_bits;

    assign w_cw       = {r_hi, r_lo};
    assign w_is_last  = (r_k == c_last_k);
    assign w_k_x2     = r_k << 1;
    assign w_in_addr  = c_in_base + w_k_x2;
    assign w_out_addr = c_out_base + w_k_x2;

    // Syndrome, overall parity, single-bit correction and flag selection.
    always_comb begin
        w_syn   = 4'd0;
        w_par   = ^w_cw;
        w_fix   = w_cw;
        w_flags = c_flag_clean;
        for (int i = 1; i < 16; i++) begin
            if (w_cw[i]) begin
                w_syn = w_syn ^ i[3:0];
            end
        end
        if (w_par) begin
            // Odd overall parity: one flipped bit at position w_syn
            // (position 0 is the overall parity bit itself).
            w_fix[w_syn] = ~w_cw[w_syn];
            w_flags      = c_flag_corrected;
        end else if (w_syn != 4'd0) begin
            // Even parity with a nonzero syndrome: two flips, leave as is.
            w_flags = c_flag_double;
        end
    end

    // Data bits sit at the non-power-of-two positions of the codeword.
    assign w_data = {w_fix[15:9], w_fix[7:5], w_fix[3]};

    // Parity positions carry no data once correction is done.
    assign w_unused_parity_bits = ^{w_fix[8], w_fix[4], w_fix[2:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: five states per word, busy states ignore req.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req) w_state_next = RD_LO;
            RD_LO:   w_state_next = RD_HI;
            RD_HI:   w_state_next = CHECK;
            CHECK:   w_state_next = WR_LO;
            WR_LO:   w_state_next = WR_HI;
            WR_HI:   w_state_next = w_is_last ? DONE : RD_LO;
            DONE:    if (req) w_state_next = RD_LO;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath registers: word index, latched bytes, decode result, ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k     <= 8'd0;
            r_lo    <= 8'd0;
            r_hi    <= 8'd0;
            r_data  <= 11'd0;
            r_flags <= 2'b00;
            r_ack   <= 1'b0;
        end else begin
            // ack rises one edge after DONE is entered and drops on req.
            r_ack <= (r_state == DONE) && !req;
            case (r_state)
                IDLE, DONE: begin
                    if (req) begin
                        r_k <= 8'd0;
                    end
                end
                RD_LO: r_lo <= mem_rd_data;
                RD_HI: r_hi <= mem_rd_data;
                CHECK: begin
                    r_data  <= w_data;
                    r_flags <= w_flags;
                end
                WR_HI: begin
                    if (!w_is_last) begin
                        r_k <= r_k + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory interface decode from the registered state.
    always_comb begin
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        case (r_state)
            RD_LO: mem_addr = w_in_addr;
            RD_HI: mem_addr = w_in_addr + 8'd1;
            WR_LO: begin
                mem_addr    = w_out_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = r_data[7:0];
            end
            WR_HI: begin
                mem_addr    = w_out_addr + 8'd1;
                mem_wr_en   = 1'b1;
                mem_wr_data = {r_flags, 3'b000, r_data[10:8]};
            end
            default: ;
        endcase
    end

    assign ack = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_hamming_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_decode_unit
// Description : Directed bench for hamming_decode_unit with a byte memory
//               model and hand-computed expected output bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_decode_unit;

    localparam int IN_BASE   = 64;
    localparam int OUT_BASE  = 94;
    localparam int NUM_WORDS = 15;

    logic       clk;
    logic       reset;
    logic       req;
    logic       ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [256];
    int         wr_count;
    int         bad_wr_count;

    int n_check;
    int n_pass;
    int n_fail;

    logic [15:0] cw_tab [NUM_WORDS];
    logic [7:0]  lo_tab [NUM_WORDS];
    logic [7:0]  hi_tab [NUM_WORDS];

    hamming_decode_unit #(
        .IN_BASE   (IN_BASE),
        .OUT_BASE  (OUT_BASE),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    // Memory write port plus write accounting.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_count      <= wr_count + 1;
            if (mem_addr < 8'(OUT_BASE) || mem_addr > 8'(OUT_BASE + 2 * NUM_WORDS - 1)) begin
                bad_wr_count <= bad_wr_count + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_inputs(input bit all_zero);
        for (int k = 0; k < NUM_WORDS; k++) begin
            mem[IN_BASE + 2 * k]     = all_zero ? 8'h00 : cw_tab[k][7:0];
            mem[IN_BASE + 2 * k + 1] = all_zero ? 8'h00 : cw_tab[k][15:8];
        end
    endtask

    task automatic fill_outputs();
        for (int a = OUT_BASE; a < OUT_BASE + 2 * NUM_WORDS; a++) begin
            mem[a] = 8'hAA;
        end
    endtask

    task automatic check_outputs(input string run, input bit all_zero);
        for (int k = 0; k < NUM_WORDS; k++) begin
            check($sformatf("%s_lo%0d", run, k), 32'(mem[OUT_BASE + 2 * k]),
                  all_zero ? 32'h00 : 32'(lo_tab[k]));
            check($sformatf("%s_hi%0d", run, k), 32'(mem[OUT_BASE + 2 * k + 1]),
                  all_zero ? 32'h00 : 32'(hi_tab[k]));
        end
    endtask

    // Pulse req so that exactly one rising edge samples it.
    task automatic start_req();
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    // Count edges until ack is high; optionally hold req for 3 edges mid-run.
    task automatic wait_ack(input int req_at, output int n);
        n = 0;
        while (n < 300 && !ack) begin
            @(posedge clk);
            #1;
            n++;
            if (n == req_at)     req = 1'b1;
            if (n == req_at + 3) req = 1'b0;
        end
        req = 1'b0;
    endtask

    int edges;
    int wr_snap;

    initial begin
        n_check      = 0;
        n_pass       = 0;
        n_fail       = 0;
        wr_count     = 0;
        bad_wr_count = 0;
        reset        = 1'b1;
        req          = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        cw_tab[0]  = 16'hFFFF; lo_tab[0]  = 8'hFF; hi_tab[0]  = 8'h07;
        cw_tab[1]  = 16'hFFDF; lo_tab[1]  = 8'hFF; hi_tab[1]  = 8'h47;
        cw_tab[2]  = 16'hFFFE; lo_tab[2]  = 8'hFF; hi_tab[2]  = 8'h47;
        cw_tab[3]  = 16'hFBF7; lo_tab[3]  = 8'hDE; hi_tab[3]  = 8'h87;
        cw_tab[4]  = 16'h0001; lo_tab[4]  = 8'h00; hi_tab[4]  = 8'h40;
        cw_tab[5]  = 16'h0002; lo_tab[5]  = 8'h00; hi_tab[5]  = 8'h40;
        cw_tab[6]  = 16'h0008; lo_tab[6]  = 8'h00; hi_tab[6]  = 8'h40;
        cw_tab[7]  = 16'h8000; lo_tab[7]  = 8'h00; hi_tab[7]  = 8'h40;
        cw_tab[8]  = 16'h0006; lo_tab[8]  = 8'h00; hi_tab[8]  = 8'h80;
        cw_tab[9]  = 16'h000F; lo_tab[9]  = 8'h01; hi_tab[9]  = 8'h00;
        cw_tab[10] = 16'h000B; lo_tab[10] = 8'h01; hi_tab[10] = 8'h40;
        cw_tab[11] = 16'h0007; lo_tab[11] = 8'h01; hi_tab[11] = 8'h40;
        cw_tab[12] = 16'h0000; lo_tab[12] = 8'h00; hi_tab[12] = 8'h00;
        cw_tab[13] = 16'h0000; lo_tab[13] = 8'h00; hi_tab[13] = 8'h00;
        cw_tab[14] = 16'h0000; lo_tab[14] = 8'h00; hi_tab[14] = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_wr_en", 32'(mem_wr_en), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wr_data", 32'(mem_wr_data), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ack", 32'(ack), 32'h0);
        check("idle_addr", 32'(mem_addr), 32'h0);

        // Run 1: mixed clean / corrected / double-error codewords.
        load_inputs(1'b0);
        fill_outputs();
        wr_snap = wr_count;
        start_req();
        check("run1_ack_low", 32'(ack), 32'h0);
        wait_ack(-10, edges);
        check("run1_latency", 32'(edges), 32'd76);
        check("run1_writes", 32'(wr_count - wr_snap), 32'd30);
        check_outputs("run1", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("done_ack_hold", 32'(ack), 32'h1);
        check("done_wr_en", 32'(mem_wr_en), 32'h0);
        check("done_addr", 32'(mem_addr), 32'h0);

        // Run 2: restart from DONE, req held 3 cycles mid-run.
        fill_outputs();
        wr_snap = wr_count;
        start_req();
        check("run2_ack_drop", 32'(ack), 32'h0);
        wait_ack(20, edges);
        check("run2_latency", 32'(edges), 32'd76);
        check("run2_writes", 32'(wr_count - wr_snap), 32'd30);
        check_outputs("run2", 1'b0);

        // Run 3: reset in the middle of word 7.
        fill_outputs();
        start_req();
        repeat (36) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_snap = wr_count;
        check("abort_ack", 32'(ack), 32'h0);
        check("abort_wr_en", 32'(mem_wr_en), 32'h0);
        check("abort_addr", 32'(mem_addr), 32'h0);
        repeat (100) @(posedge clk);
        #1;
        check("abort_ack_stays", 32'(ack), 32'h0);
        check("abort_no_writes", 32'(wr_count - wr_snap), 32'd0);
        check("abort_w6_written", 32'(mem[OUT_BASE + 13]), 32'(hi_tab[6]));
        check("abort_w7_untouched", 32'(mem[OUT_BASE + 14]), 32'hAA);

        // Run 4: all-zero codewords after the abort.
        load_inputs(1'b1);
        wr_snap = wr_count;
        start_req();
        wait_ack(-10, edges);
        check("run4_latency", 32'(edges), 32'd76);
        check("run4_writes", 32'(wr_count - wr_snap), 32'd30);
        check_outputs("run4", 1'b1);
        check("stray_writes", 32'(bad_wr_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
`default_nettype wire
